spi_speed_ramp: RTL and testbench



---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_ramp_step.sv | 61 ++++++
 rtl/spi_speed_ramp.sv | 110 +++++++++++
 tb/tb_spi_speed_ramp.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types for the SPI speed ramp: FSM state encoding, speed word type
// and a sign-extension helper used by the 17-bit difference arithmetic.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_ESTOP = 2'd2
  } ramp_state_e;

  typedef logic signed [15:0] speed_t;

  // Widen a speed word to 17 bits so differences near full scale cannot wrap.
  function automatic logic signed [16:0] sext17(input speed_t v);
    return {v[15], v};
  endfunction

endpackage

// File: rtl/spi_ramp_step.sv
// Combinational step/clamp: computes the next speed word from the current one
// and the effective target. Moving away from zero uses STEP_UP limited by the
// remaining distance; moving toward zero uses STEP_DOWN limited so the result
// never crosses zero nor passes the target in a single update.
module spi_ramp_step
  import spi_pkg::*;
#(
  parameter logic [15:0] STEP_UP   = 16'd64,
  parameter logic [15:0] STEP_DOWN = 16'd128
) (
  input  speed_t current,
  input  speed_t target,
  output speed_t next
);

  localparam logic signed [16:0] UP17   = {1'b0, STEP_UP};
  localparam logic signed [16:0] DOWN17 = {1'b0, STEP_DOWN};

  logic signed [16:0] cur_s;
  logic signed [16:0] tgt_s;
  logic signed [16:0] diff_s;
  logic signed [16:0] cur_mag_s;
  logic signed [16:0] tgt_mag_s;
  logic signed [16:0] diff_mag_s;
  logic signed [16:0] limit_s;
  logic               same_sign_s;
  logic               away_s;
  speed_t             step_s;

  // Classify the move direction and pick a bounded step magnitude.
  always_comb begin
    cur_s       = sext17(current);
    tgt_s       = sext17(target);
    diff_s      = tgt_s - cur_s;
    cur_mag_s   = cur_s[16]  ? (17'sd0 - cur_s)  : cur_s;
    tgt_mag_s   = tgt_s[16]  ? (17'sd0 - tgt_s)  : tgt_s;
    diff_mag_s  = diff_s[16] ? (17'sd0 - diff_s) : diff_s;
    same_sign_s = (cur_s[16] == tgt_s[16]) && (tgt_s != 17'sd0);
    away_s      = (cur_s == 17'sd0) || (same_sign_s && (tgt_mag_s > cur_mag_s));

    // Toward zero: stop on the target if it lies on this side, else on zero.
    if (same_sign_s) begin
      limit_s = cur_mag_s - tgt_mag_s;
    end else begin
      limit_s = cur_mag_s;
    end

    if (away_s) begin
      step_s = (diff_mag_s < UP17) ? diff_mag_s[15:0] : UP17[15:0];
    end else begin
      step_s = (limit_s < DOWN17) ? limit_s[15:0] : DOWN17[15:0];
    end

    if (away_s) begin
      next = diff_s[16] ? (current - step_s) : (current + step_s);
    end else begin
      next = cur_s[16] ? (current + step_s) : (current - step_s);
    end
  end

endmodule

// File: rtl/spi_speed_ramp.sv
// Speed ramp controller feeding the SPI shifter parallel input. The speed word
// advances one bounded step per completed SPI transfer toward an effective
// target; an emergency stop forces zero and latches until re-armed.
module spi_speed_ramp
  import spi_pkg::*;
#(
  parameter logic        [15:0] STEP_UP   = 16'd64,
  parameter logic        [15:0] STEP_DOWN = 16'd128,
  parameter logic signed [15:0] MAX_SPEED = 16'sd16000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] i_target,
  input  logic               i_enable,
  input  logic               i_estop,
  input  logic               i_xfer_done,
  output logic signed [15:0] o_speed,
  output logic               o_at_target,
  output logic               o_ramping,
  output logic               o_estop_latched
);

  ramp_state_e state_r;
  ramp_state_e state_nxt_s;
  speed_t      speed_r;
  speed_t      speed_nxt_s;
  speed_t      eff_tgt_s;
  speed_t      step_next_s;
  logic        at_target_r;
  logic        ramping_r;
  logic        estop_r;

  // Effective target: zero when disabled, otherwise clamped to +/-MAX_SPEED.
  always_comb begin
    if (!i_enable) begin
      eff_tgt_s = 16'sd0;
    end else if (sext17(i_target) > sext17(MAX_SPEED)) begin
      eff_tgt_s = MAX_SPEED;
    end else if (sext17(i_target) < (17'sd0 - sext17(MAX_SPEED))) begin
      eff_tgt_s = 16'sd0 - MAX_SPEED;
    end else begin
      eff_tgt_s = i_target;
    end
  end

  spi_ramp_step #(
    .STEP_UP   (STEP_UP),
    .STEP_DOWN (STEP_DOWN)
  ) u_step (
    .current (speed_r),
    .target  (eff_tgt_s),
    .next    (step_next_s)
  );

  // Next-state and next-speed decode; estop overrides any transfer pulse.
  always_comb begin
    state_nxt_s = state_r;
    speed_nxt_s = speed_r;
    case (state_r)
      ST_ESTOP: begin
        speed_nxt_s = 16'sd0;
        if (!i_estop && !i_enable) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ESTOP;
        end
      end
      ST_IDLE, ST_RAMP: begin
        if (i_estop) begin
          speed_nxt_s = 16'sd0;
          state_nxt_s = ST_ESTOP;
        end else begin
          if (i_xfer_done) begin
            speed_nxt_s = step_next_s;
          end else begin
            speed_nxt_s = speed_r;
          end
          state_nxt_s = (speed_nxt_s == eff_tgt_s) ? ST_IDLE : ST_RAMP;
        end
      end
      default: begin
        speed_nxt_s = 16'sd0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, speed and status flags all register together so they stay coherent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      speed_r     <= 16'sd0;
      at_target_r <= 1'b1;
      ramping_r   <= 1'b0;
      estop_r     <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      speed_r     <= speed_nxt_s;
      at_target_r <= (speed_nxt_s == eff_tgt_s);
      ramping_r   <= (state_nxt_s == ST_RAMP);
      estop_r     <= (state_nxt_s == ST_ESTOP);
    end
  end

  assign o_speed         = speed_r;
  assign o_at_target     = at_target_r;
  assign o_ramping       = ramping_r;
  assign o_estop_latched = estop_r;

endmodule

// File: tb/tb_spi_speed_ramp.sv
// Scoreboard bench for spi_speed_ramp: stimulus pushes the expected outputs
// for every transfer/estop pulse, a monitor pops and compares one cycle later.
module tb_spi_speed_ramp;

  logic               clk;
  logic               rst;
  logic signed [15:0] i_target;
  logic               i_enable;
  logic               i_estop;
  logic               i_xfer_done;
  logic signed [15:0] o_speed;
  logic               o_at_target;
  logic               o_ramping;
  logic               o_estop_latched;

  typedef struct {
    int   speed;
    logic at;
    logic rmp;
    logic est;
    int   id;
  } exp_t;

  exp_t q[$];
  int   checks;
  int   failures;
  int   next_id;
  logic pend;

  spi_speed_ramp dut (
    .clk             (clk),
    .rst             (rst),
    .i_target        (i_target),
    .i_enable        (i_enable),
    .i_estop         (i_estop),
    .i_xfer_done     (i_xfer_done),
    .o_speed         (o_speed),
    .o_at_target     (o_at_target),
    .o_ramping       (o_ramping),
    .o_estop_latched (o_estop_latched)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive one pulse (transfer and/or estop) and queue the expected response.
  task automatic pulse(input logic xf, input logic es, input int sp,
                       input logic at, input logic rmp, input logic est);
    exp_t e;
    @(negedge clk);
    i_xfer_done = xf;
    i_estop     = es;
    e.speed = sp; e.at = at; e.rmp = rmp; e.est = est; e.id = next_id;
    next_id++;
    q.push_back(e);
    @(negedge clk);
    i_xfer_done = 1'b0;
    i_estop     = 1'b0;
  endtask

  // Note which edges carried a pulse so the monitor knows when to compare.
  always @(posedge clk) pend <= i_xfer_done | i_estop;

  // Monitor: compare DUT outputs against the head of the scoreboard.
  always @(negedge clk) begin
    if (pend) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty: got speed %0d with nothing expected", o_speed);
      end else begin
        exp_t e;
        e = q.pop_front();
        checks += 4;
        if (int'(o_speed) != e.speed) begin
          failures++;
          $display("FAIL speed id=%0d: got %0d expected %0d", e.id, o_speed, e.speed);
        end
        if (o_at_target != e.at) begin
          failures++;
          $display("FAIL at_target id=%0d: got %0b expected %0b", e.id, o_at_target, e.at);
        end
        if (o_ramping != e.rmp) begin
          failures++;
          $display("FAIL ramping id=%0d: got %0b expected %0b", e.id, o_ramping, e.rmp);
        end
        if (o_estop_latched != e.est) begin
          failures++;
          $display("FAIL estop_latched id=%0d: got %0b expected %0b", e.id, o_estop_latched, e.est);
        end
      end
    end
  end

  initial begin
    int e;
    checks      = 0;
    failures    = 0;
    next_id     = 0;
    pend        = 1'b0;
    rst         = 1'b1;
    i_target    = 16'sd0;
    i_enable    = 1'b0;
    i_estop     = 1'b0;
    i_xfer_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_speed", int'(o_speed), 0);
    chk("reset_at_target", int'(o_at_target), 1);
    chk("reset_ramping", int'(o_ramping), 0);
    chk("reset_estop", int'(o_estop_latched), 0);
    rst = 1'b0;
    @(negedge clk);

    // Ramp up 0 -> 200.
    i_enable = 1'b1;
    i_target = 16'sd200;
    repeat (2) @(negedge clk);
    chk("ramp_start_at_target", int'(o_at_target), 0);
    chk("ramp_start_ramping", int'(o_ramping), 1);
    pulse(1'b1, 1'b0,  64, 1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 128, 1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 192, 1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 200, 1'b1, 1'b0, 1'b0);

    // Sign reversal 200 -> -100 must land on zero.
    i_target = -16'sd100;
    pulse(1'b1, 1'b0,   72, 1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0,    0, 1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0,  -64, 1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, -100, 1'b1, 1'b0, 1'b0);

    // Target changes without transfers leave the speed untouched.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      i_target = (i % 2 == 0) ? 16'sd5000 : -16'sd3000;
    end
    i_target = 16'sd5000;
    @(negedge clk);
    chk("hold_speed", int'(o_speed), -100);
    @(negedge clk);
    chk("hold_ramping", int'(o_ramping), 1);

    // Full-scale target saturates at 16000.
    i_target = 16'sh7FFF;
    pulse(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    e = 0;
    for (int k = 0; k < 255; k++) begin
      e = (e + 64 > 16000) ? 16000 : e + 64;
      pulse(1'b1, 1'b0, e, (e == 16000), (e != 16000), 1'b0);
    end

    // Reset mid-ramp discards progress.
    i_target = 16'sd1000;
    pulse(1'b1, 1'b0, 15872, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_speed", int'(o_speed), 0);
    chk("midrst_at_target", int'(o_at_target), 1);
    @(negedge clk);
    rst = 1'b0;
    pulse(1'b1, 1'b0,  64, 1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 128, 1'b0, 1'b1, 1'b0);

    // Emergency stop at 128, simultaneous with a transfer; estop wins.
    pulse(1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("estop_hold_enabled", int'(o_estop_latched), 1);
    i_enable = 1'b0;
    @(negedge clk);
    chk("rearm_estop", int'(o_estop_latched), 0);
    chk("rearm_speed", int'(o_speed), 0);
    chk("rearm_at_target", int'(o_at_target), 1);
    chk("rearm_ramping", int'(o_ramping), 0);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
